// File: rtl/sol1_dma_pkg.sv
// sol1_dma_pkg: shared types and constants for the DMA bus arbiter.
package sol1_dma_pkg;

    localparam int unsigned NREQ             = 4;
    localparam int unsigned MAX_HOLD_DEFAULT = 64;

    typedef logic [1:0] owner_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGrant,
        StRelease
    } state_t;

    // One-hot vector with only the bit of the given requester set.
    function automatic logic [NREQ-1:0] owner_onehot(input owner_t idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requesters.
// The search starts just after 'last' and wraps; idx is meaningful only when valid=1.
module rr_pick4
    import sol1_dma_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  owner_t          last,
    output logic            valid,
    output owner_t          idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        owner_t cand;
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + owner_t'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin arbiter handing the CPU bus to one of four DMA requesters.
// A winner is chosen only in IDLE, the CPU is asked to release the bus, and the grant is
// held until the owner drops its request or the CPU withdraws its acknowledge.
// Optional hold-timeout preemption is enabled by defining DMA_ARB_PREEMPT_EN.
module dma_arbiter
    import sol1_dma_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            cpu_dma_req,
    input  logic            cpu_dma_ack,
    output logic [1:0]      owner,
    output logic            preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("dma_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t last_q, last_d;
    logic   pick_valid;
    owner_t pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef DMA_ARB_PREEMPT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       timeout;
    logic       preempt_q;

    // Timeout only counts while the grant would otherwise continue and someone else waits.
    assign timeout = (state_q == StGrant) && (hold_q == HoldLast) && req[owner_q] &&
                     cpu_dma_ack && |(req & ~owner_onehot(owner_q));

    // Hold counter: cleared outside GRANT so each grant starts at zero, saturates at the limit.
    always_ff @(posedge clk) begin
        if (arst) begin
            hold_q <= '0;
        end else if (state_q != StGrant) begin
            hold_q <= '0;
        end else if (hold_q != HoldLast) begin
            hold_q <= hold_q + 8'd1;
        end
    end

    // One-cycle preempt pulse raised on the edge that ends a grant by timeout.
    always_ff @(posedge clk) begin
        if (arst) begin
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= timeout;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    // Next-state logic: arbitration happens only in IDLE; pointer advances on RELEASE->IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A requester that gives up before the ack never sees a grant.
                if (!req[owner_q]) begin
                    state_d = StRelease;
                end else if (cpu_dma_ack) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!req[owner_q] || !cpu_dma_ack) begin
                    state_d = StRelease;
                end
`ifdef DMA_ARB_PREEMPT_EN
                else if (timeout) begin
                    state_d = StRelease;
                end
`endif
            end
            StRelease: begin
                if (!cpu_dma_ack) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= owner_t'(NREQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt         = (state_q == StGrant) ? owner_onehot(owner_q) : '0;
    assign cpu_dma_req = (state_q == StReq) || (state_q == StGrant);
    assign owner       = owner_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: scoreboard bench for dma_arbiter with a bus-tenure reference model.
// Build with DMA_ARB_PREEMPT_EN defined to exercise hold-timeout preemption (MAX_HOLD=8).
module tb_dma_arbiter;

    localparam int unsigned MAX_HOLD = 8;
`ifdef DMA_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req;
    logic       cpu_dma_ack;
    logic [3:0] gnt;
    logic       cpu_dma_req;
    logic [1:0] owner;
    logic       preempt;

    dma_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .arst        (arst),
        .req         (req),
        .gnt         (gnt),
        .cpu_dma_req (cpu_dma_req),
        .cpu_dma_ack (cpu_dma_ack),
        .owner       (owner),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model: one bus tenure at a time ----------------
    typedef enum int {PhFree, PhAsk, PhBus, PhDrop} phase_t;
    typedef struct {
        logic [3:0] gnt;
        logic       cpu_req;
        logic [1:0] owner;
        logic       pre;
        logic       chk_owner;
    } exp_t;

    exp_t   exp_q[$];
    int     grant_q[$];
    int     obs_log[$];
    phase_t m_phase = PhFree;
    int     m_owner = 0;
    int     m_last  = 3;
    int     m_held  = 0;
    bit     m_pre   = 1'b0;

    task automatic model_step();
        bit   found;
        exp_t e;
        m_pre = 1'b0;
        if (arst) begin
            m_phase = PhFree;
            m_owner = 0;
            m_last  = 3;
            m_held  = 0;
        end else begin
            case (m_phase)
                PhFree: begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last + k) % 4;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                            m_phase = PhAsk;
                        end
                    end
                end
                PhAsk: begin
                    if (!req[m_owner]) m_phase = PhDrop;
                    else if (cpu_dma_ack) begin
                        m_phase = PhBus;
                        m_held  = 1;
                        grant_q.push_back(m_owner);
                    end
                end
                PhBus: begin
                    if (!req[m_owner] || !cpu_dma_ack) m_phase = PhDrop;
                    else if (PREEMPT && m_held >= MAX_HOLD &&
                             (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                        m_phase = PhDrop;
                        m_pre   = 1'b1;
                    end else m_held++;
                end
                default: begin
                    if (!cpu_dma_ack) begin
                        m_phase = PhFree;
                        m_last  = m_owner;
                    end
                end
            endcase
        end
        e.gnt       = (m_phase == PhBus) ? (4'b0001 << m_owner) : 4'b0000;
        e.cpu_req   = (m_phase == PhAsk) || (m_phase == PhBus);
        e.owner     = 2'(m_owner);
        e.pre       = m_pre;
        e.chk_owner = e.cpu_req || arst;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) model_step();

    // ---------------- monitor: pops expectations, tracks grant order ----------------
    exp_t       mon_e;
    logic [3:0] prev_gnt = 4'b0000;
    int         pre_cnt  = 0;
    int         mon_idx;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(mon_e.gnt));
            check("cpu_dma_req", 32'(cpu_dma_req), 32'(mon_e.cpu_req));
            check("preempt", 32'(preempt), 32'(mon_e.pre));
            if (mon_e.chk_owner) check("owner", 32'(owner), 32'(mon_e.owner));
        end
        if (preempt === 1'b1) pre_cnt++;
        if (gnt !== 4'b0000 && gnt !== prev_gnt) begin
            check("gnt_onehot", $countones(gnt), 1);
            mon_idx = 0;
            for (int i = 3; i >= 0; i--) if (gnt[i]) mon_idx = i;
            if (grant_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL grant_order: got grant to %0d, required no grant", mon_idx);
            end else begin
                check("grant_order", mon_idx, grant_q.pop_front());
            end
            obs_log.push_back(mon_idx);
        end
        prev_gnt = gnt;
    end

    // ---------------- driver: requesters and CPU behaviour ----------------
    int         remaining[4];
    int         gap[4];
    bit         abandon[4];
    logic [3:0] en_mask   = 4'b0000;
    bit         rand_mode = 1'b0;
    int         fixed_hold = 5;
    int         ack_delay  = 3;
    int         rel_delay  = 1;
    int         ack_cnt    = 0;
    int         rel_cnt    = 0;

    always @(negedge clk) begin
        if (!arst) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        remaining[i]--;
                        if (remaining[i] <= 0) begin
                            req[i] = 1'b0;
                            gap[i] = rand_mode ? int'($urandom_range(0, 6)) : 1;
                        end
                    end else if (abandon[i] && cpu_dma_req && owner == 2'(i) && gnt == 4'b0000) begin
                        req[i]     = 1'b0;
                        abandon[i] = 1'b0;
                        gap[i]     = 2;
                    end
                end else if (en_mask[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        req[i]       = 1'b1;
                        remaining[i] = rand_mode ? int'($urandom_range(1, 12)) : fixed_hold;
                        if (rand_mode && $urandom_range(0, 7) == 0) abandon[i] = 1'b1;
                    end
                end
            end
        end
        if (cpu_dma_req) begin
            rel_cnt = 0;
            if (!cpu_dma_ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    cpu_dma_ack = 1'b1;
                    ack_cnt     = 0;
                end
            end else if (rand_mode && gnt != 4'b0000 && $urandom_range(0, 39) == 0) begin
                cpu_dma_ack = 1'b0;
            end
        end else begin
            ack_cnt = 0;
            if (cpu_dma_ack) begin
                rel_cnt++;
                if (rel_cnt >= rel_delay) begin
                    cpu_dma_ack = 1'b0;
                    rel_cnt     = 0;
                end
            end
        end
        if (rand_mode) begin
            ack_delay = $urandom_range(1, 3);
            rel_delay = $urandom_range(1, 3);
        end
    end

    // ---------------- directed phases and random run ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [3:0] want, input int budget, input string name);
        int n = 0;
        while (gnt !== want && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(gnt), 32'(want));
    endtask

    task automatic wait_log(input int target, input int budget, input string name);
        int n = 0;
        while (obs_log.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(obs_log.size() >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(req == 4'b0000 && !cpu_dma_req && !cpu_dma_ack && gnt == 4'b0000) && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(req == 4'b0000 && !cpu_dma_req && !cpu_dma_ack), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int base;
    int pre_base;
    int streak;
    int n;

    initial begin
        arst        = 1'b1;
        req         = 4'b0000;
        cpu_dma_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 0;
            gap[i]       = 0;
            abandon[i]   = 1'b0;
        end
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_cpu_dma_req", 32'(cpu_dma_req), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_preempt", 32'(preempt), 0);
        arst = 1'b0;
        tick();

        // All four request; each holds 5 grant cycles; ack 3 cycles after cpu_dma_req.
        base = obs_log.size();
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 5;
            gap[i]       = 1;
        end
        fixed_hold = 5;
        req        = 4'b1111;
        en_mask    = 4'b1111;
        wait_log(base + 5, 400, "rr_order_reached");
        if (obs_log.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", obs_log[base + k], exp_order[k]);
        end
        en_mask = 4'b0000;
        wait_idle(400);

        // Requester 2 gives up before the ack, then comes back and is served.
        base       = obs_log.size();
        fixed_hold = 4;
        abandon[2] = 1'b1;
        remaining[2] = 4;
        gap[2]     = 2;
        en_mask    = 4'b0100;
        req[2]     = 1'b1;
        wait_log(base + 1, 200, "abandon_regrant_reached");
        if (obs_log.size() > base) check("abandon_regrant", obs_log[base], 2);
        check("abandon_seen", 32'(abandon[2]), 0);
        en_mask = 4'b0000;
        wait_idle(300);

        // Long hold by requester 0 while requester 1 waits.
        base         = obs_log.size();
        pre_base     = pre_cnt;
        remaining[0] = 30;
        req[0]       = 1'b1;
        wait_gnt(4'b0001, 50, "hold_gnt0");
        remaining[1] = 3;
        req[1]       = 1'b1;
        streak       = 0;
        n            = 0;
        while (gnt[0] === 1'b1 && n < 100) begin
            streak++;
            tick();
            n++;
        end
        check("hold_len", streak, PREEMPT ? MAX_HOLD : 30);
        wait_log(base + 2, 200, "hold_next_reached");
        if (obs_log.size() >= base + 2) check("hold_next_owner", obs_log[base + 1], 1);
        wait_idle(300);
        check("preempt_count", pre_cnt - pre_base, PREEMPT ? 1 : 0);

        // Reset in the middle of a grant to requester 2.
        remaining[2] = 50;
        req[2]       = 1'b1;
        wait_gnt(4'b0100, 50, "mid_rst_gnt2");
        arst         = 1'b1;
        req          = 4'b0110;
        remaining[1] = 3;
        remaining[2] = 3;
        tick();
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_cpu_dma_req", 32'(cpu_dma_req), 0);
        base = obs_log.size();
        arst = 1'b0;
        wait_log(base + 1, 100, "post_rst_reached");
        if (obs_log.size() > base) check("post_rst_winner", obs_log[base], 1);
        wait_idle(300);

        // Randomised traffic with ack drops and occasional resets.
        rand_mode = 1'b1;
        en_mask   = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            tick();
            arst = ($urandom_range(0, 399) == 0);
        end
        arst      = 1'b0;
        rand_mode = 1'b0;
        en_mask   = 4'b0000;
        for (int i = 0; i < 4; i++) abandon[i] = 1'b0;
        ack_delay = 3;
        rel_delay = 1;
        wait_idle(800);

        @(negedge clk);
        #1;
        check("grant_q_drained", grant_q.size(), 0);
        check("progress", 32'(obs_log.size() > 40), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 64, maximum grant length in clk cycles before preemption; legal range 2..255.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 arst  in  1  reset, synchronous, active-high.
REQ-004 req  in  4  bus requests from DMA requesters 0..3; level, held until done.
REQ-005 gnt  out  4  one-hot bus grant; all-zero when no owner.
REQ-006 cpu_dma_req  out  1  drives cpu_top dma_req.
REQ-007 cpu_dma_ack  in  1  from cpu_top dma_ack; high = CPU has released the bus.
REQ-008 owner  out  2  index of the current or pending owner; valid while cpu_dma_req=1.
REQ-009 preempt  out  1  one-cycle pulse when a grant is ended by hold timeout.

Function
REQ-010 The FSM SHALL have states IDLE, REQ, GRANT and RELEASE; all outputs SHALL be registered or decoded from registered state only.
REQ-011 IDLE: if any req bit is sampled high, the block SHALL latch a winner into owner and enter REQ; cpu_dma_req rises on that same edge.
REQ-012 Winner selection SHALL be round-robin: search starts at (last_owner+1) mod 4 and wraps; last_owner is updated on RELEASE->IDLE.
REQ-013 REQ: cpu_dma_ack=1 -> GRANT; gnt[owner] rises on that edge. If req[owner] drops before ack -> RELEASE, with no gnt pulse.
REQ-014 GRANT: gnt[owner]=1 and cpu_dma_req=1; the hold counter SHALL start at 0 on entry and increment every cycle, saturating at MAX_HOLD-1.
REQ-015 GRANT: req[owner]=0 -> RELEASE on the next edge; gnt and cpu_dma_req fall on that edge.
REQ-016 GRANT: cpu_dma_ack falling while granted SHALL force RELEASE; gnt falls on the next edge.
REQ-017 RELEASE: cpu_dma_req=0 and gnt=0; stay until cpu_dma_ack=0, then enter IDLE. A new arbitration SHALL NOT start in the same cycle.
REQ-018 Simultaneous requests SHALL be resolved only in IDLE; requests arriving during REQ, GRANT or RELEASE wait, and no request is dropped.
REQ-019 At most one gnt bit SHALL be high in any cycle, and gnt SHALL never be high while cpu_dma_ack=0 was sampled on the previous edge.

Reset
REQ-020 While arst=1 on an edge: state=IDLE, gnt=0, cpu_dma_req=0, owner=0, last_owner=3 (requester 0 first after reset), hold counter=0, preempt=0.
REQ-021 Reset asserted mid-grant SHALL drop gnt and cpu_dma_req on that same edge, regardless of cpu_dma_ack.

Configuration
REQ-022 Macro DMA_ARB_PREEMPT_EN defined: GRANT with counter=MAX_HOLD-1 and any other req bit high SHALL go to RELEASE and pulse preempt for one cycle; gnt is held exactly MAX_HOLD cycles.
REQ-023 DMA_ARB_PREEMPT_EN undefined: no timeout; the owner holds until it drops req; preempt SHALL be tied 0 and the hold counter omitted.

Structure
REQ-024 Package sol1_dma_pkg SHALL hold the state enum, NREQ=4, the owner index typedef and the MAX_HOLD default constant.
REQ-025 A sub-module rr_pick4 (combinational round-robin picker: inputs req[3:0] and last[1:0]; outputs valid and idx[1:0]) SHALL be instantiated once.

Verification
REQ-026 After reset, req=4'b1111 with ack 3 cycles after cpu_dma_req -> grant order 0,1,2,3,0 as each owner drops req after 5 grant cycles.
REQ-027 req[2] pulses 1 cycle before ack -> REQ->RELEASE, gnt stays 0, cpu_dma_req falls; req[2] is re-served after it reasserts.
REQ-028 With PREEMPT_EN and MAX_HOLD=8: req0 held and req1 rises -> gnt[0] high exactly 8 cycles, preempt pulses once, then gnt[1] after the next ack.
REQ-029 Without PREEMPT_EN, same stimulus -> gnt[0] stays high until req0 drops, and preempt stays 0.
REQ-030 arst=1 while gnt=4'b0100 -> gnt=0 and cpu_dma_req=0 on that edge; after release, req=4'b0110 -> requester 1 wins.
REQ-031 cpu_dma_ack forced low during GRANT -> gnt falls next edge, state RELEASE, then IDLE once ack=0 is sampled.
